// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int calc_bit_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: wrap-bit pointers, registered read port, async active-low reset.
module uart_rx_fifo #(
    parameter int WIDTH  = 8,
    parameter int SIZE_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 2**SIZE_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE_W:0]  wr_ptr;
    logic [SIZE_W:0]  rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[SIZE_W] != rd_ptr[SIZE_W]) &&
                   (wr_ptr[SIZE_W-1:0] == rd_ptr[SIZE_W-1:0]);

    // A pop in the same cycle frees the slot, so a write while full is still accepted.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[SIZE_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (SIZE_W+1)'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + (SIZE_W+1)'(1);
                rd_data <= mem[rd_ptr[SIZE_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, centre sampling, sticky error flags, byte FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 200_000_000,
    parameter int UART_BAUD = 115200,
    parameter int SIZE_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output rx_state_t  state_dbg
);

    localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, UART_BAUD);
    localparam int HALF    = BIT_CNT / 2;
    localparam int CNT_W   = $clog2(BIT_CNT) + 1;
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);

    rx_state_t        state;
    rx_state_t        state_nx;
    logic [1:0]       rx_sync;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             brk_wait;
    logic             push;
    logic             frame_evt;
    logic             overrun_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s      = rx_sync[1];
    assign tick      = (cnt == '0);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!rx_s) state_nx = START;
            START:   if (tick) state_nx = rx_s ? IDLE : DATA;
            DATA:    if (tick && bit_idx == 3'd7) state_nx = STOP;
            // After a bad stop bit, stay here until the line returns high (break hold-off).
            STOP: begin
                if (brk_wait) begin
                    if (rx_s) state_nx = IDLE;
                end else if (tick && rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        frame_evt = 1'b0;
        if (state == STOP && tick && !brk_wait) begin
            push      = rx_s;
            frame_evt = !rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            brk_wait <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt      <= HALF_LOAD;
                    bit_idx  <= '0;
                    brk_wait <= 1'b0;
                end
                START: cnt <= tick ? BIT_LOAD : cnt - CNT_W'(1);
                DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= BIT_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (!tick) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!brk_wait && !rx_s) begin
                        brk_wait <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Read handshake: rd_en is a pop request accepted only while empty is low;
    // the accepted byte appears on rd_data after the next rising edge.
    assign overrun_evt = push && full && !(rd_en && !empty);

    // Error events win over a coincident clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_evt) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (overrun_evt) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH  (8),
        .SIZE_W (SIZE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (shreg),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level byte/flag model plus directed literal checks.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int UART_BAUD = 100_000;
    localparam int SIZE_W    = 3;
    localparam int BIT       = 10;
    localparam int FRAME     = 10 * BIT;
    localparam int DEPTH     = 8;
    // Drive index whose following edge is the stop-bit sample of a frame.
    localparam int PUSH_C    = 97;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overrun;
    rx_state_t  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_rd;
    logic       m_frame_err;
    logic       m_overrun;
    bit         settled;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BAUD (UART_BAUD),
        .SIZE_W    (SIZE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model whenever the line is between frames.
    always @(negedge clk) begin
        if (settled) begin
            check("cmp_empty", 8'(empty), 8'(exp_q.size() == 0));
            check("cmp_full", 8'(full), 8'(exp_q.size() == DEPTH));
            check("cmp_frame_err", 8'(frame_err), 8'(m_frame_err));
            check("cmp_overrun", 8'(overrun), 8'(m_overrun));
            check("cmp_rd_data", rd_data, exp_rd);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic hold_low(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b0;
        end
    endtask

    // One 8N1 frame; optional pop / err_clr pulse at a given bit-cycle index.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int pop_c, input int clr_c);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        settled = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            rx      = bits[c / BIT];
            rd_en   = (c == pop_c);
            err_clr = (c == clr_c);
        end
        if (pop_c >= 0 && exp_q.size() > 0) exp_rd = exp_q.pop_front();
        if (clr_c >= 0) begin
            m_frame_err = 1'b0;
            m_overrun   = 1'b0;
        end
        if (!stop_bit) m_frame_err = 1'b1;
        else if (exp_q.size() >= DEPTH) m_overrun = 1'b1;
        else exp_q.push_back(data);
        settled = 1'b1;
    endtask

    task automatic pop_byte();
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        if (exp_q.size() > 0) exp_rd = exp_q.pop_front();
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr     = 1'b0;
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_rd      = 8'h00;
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] part;
        logic [7:0] drain [8];

        settled = 1'b0;
        rst     = 1'b1;
        rx      = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        model_reset();

        // Reset values, checked before any clock edge
        #2 rst = 1'b0;
        #1;
        check("rst_empty", 8'(empty), 8'h01);
        check("rst_full", 8'(full), 8'h00);
        check("rst_frame_err", 8'(frame_err), 8'h00);
        check("rst_overrun", 8'(overrun), 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_state", 8'(state_dbg), 8'(IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(10);
        settled = 1'b1;

        // Single valid byte
        send_frame(8'h55, 1'b1, -1, -1);
        idle(5);
        check("t55_empty", 8'(empty), 8'h00);
        pop_byte();
        check("t55_rd", rd_data, 8'h55);
        check("t55_empty_after", 8'(empty), 8'h01);
        check("t55_flags", {6'd0, frame_err, overrun}, 8'h00);

        // Start-bit glitch of 3 cycles
        idle(10);
        @(negedge clk); rx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rx = 1'b1;
        check("glitch_in_start", 8'(state_dbg), 8'(START));
        idle(20);
        check("glitch_idle", 8'(state_dbg), 8'(IDLE));
        check("glitch_empty", 8'(empty), 8'h01);
        check("glitch_flags", {6'd0, frame_err, overrun}, 8'h00);

        // Bad stop bit followed by a held break, then a good frame
        send_frame(8'hA5, 1'b0, -1, -1);
        hold_low(30);
        idle(20);
        check("ferr_set", 8'(frame_err), 8'h01);
        check("ferr_empty", 8'(empty), 8'h01);
        check("ferr_idle", 8'(state_dbg), 8'(IDLE));
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(5);
        pop_byte();
        check("ferr_next_rd", rd_data, 8'h3C);
        clear_errs();
        check("ferr_cleared", 8'(frame_err), 8'h00);

        // Nine frames into an eight-deep FIFO
        idle(10);
        for (int i = 0; i < 9; i++) send_frame(8'(8'h30 + i), 1'b1, -1, -1);
        idle(5);
        check("ovr_full", 8'(full), 8'h01);
        check("ovr_flag", 8'(overrun), 8'h01);
        for (int i = 0; i < 8; i++) begin
            pop_byte();
            check("ovr_pop", rd_data, 8'(8'h30 + i));
        end
        check("ovr_empty", 8'(empty), 8'h01);
        clear_errs();
        check("ovr_cleared", 8'(overrun), 8'h00);

        // Clear coincident with a framing error: the error wins
        idle(10);
        send_frame(8'h12, 1'b0, -1, -1);
        hold_low(30);
        idle(20);
        send_frame(8'h34, 1'b0, -1, PUSH_C);
        hold_low(30);
        idle(20);
        check("clr_vs_evt", 8'(frame_err), 8'h01);
        clear_errs();
        check("clr_done", 8'(frame_err), 8'h00);

        // Back-to-back frames, pop coincident with push while full
        idle(10);
        for (int i = 0; i < 7; i++) send_frame(8'(8'h40 + i), 1'b1, -1, -1);
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, PUSH_C, -1);
        idle(5);
        check("b2b_full", 8'(full), 8'h01);
        check("b2b_overrun", 8'(overrun), 8'h00);
        check("b2b_first_pop", rd_data, 8'h40);
        drain = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h00, 8'hFF};
        for (int i = 0; i < 8; i++) begin
            pop_byte();
            check("b2b_drain", rd_data, drain[i]);
        end

        // Reset during bit 4 of 0xFF with a byte already stored
        idle(10);
        send_frame(8'h11, 1'b1, -1, -1);
        idle(10);
        settled = 1'b0;
        part = {1'b1, 8'hFF, 1'b0};
        for (int c = 0; c < 55; c++) begin
            @(negedge clk);
            rx = part[c / BIT];
        end
        #2 rst = 1'b0;
        #1;
        check("mid_rst_empty", 8'(empty), 8'h01);
        check("mid_rst_rd", rd_data, 8'h00);
        check("mid_rst_state", 8'(state_dbg), 8'(IDLE));
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(20);
        settled = 1'b1;
        send_frame(8'h81, 1'b1, -1, -1);
        idle(5);
        check("mid_rst_one", 8'(empty), 8'h00);
        pop_byte();
        check("mid_rst_byte", rd_data, 8'h81);
        check("mid_rst_only", 8'(empty), 8'h01);
        idle(5);

        settled = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 200_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter SIZE_W, default 3, receive FIFO depth = 2**SIZE_W bytes.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rd_en  input  1  pop request for one FIFO byte.
REQ-008 SHALL have port rd_data  output  8  popped byte, registered.
REQ-009 SHALL have port empty  output  1  FIFO holds no bytes.
REQ-010 SHALL have port full  output  1  FIFO holds 2**SIZE_W bytes.
REQ-011 SHALL have port frame_err  output  1  sticky: a stop bit was sampled low.
REQ-012 SHALL have port overrun  output  1  sticky: a valid byte was dropped because the FIFO was full.
REQ-013 SHALL have port err_clr  input  1  one-cycle pulse clearing frame_err and overrun.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer reset to 1; all decisions use the synchronized value, adding 2 cycles of latency.
REQ-015 SHALL use BIT_CNT = CLK_FREQ/UART_BAUD (integer division) and HALF = BIT_CNT/2; counter width = $clog2(BIT_CNT)+1.
REQ-016 SHALL implement FSM IDLE, START, DATA, STOP.
REQ-017 IDLE: on synchronized rx = 0 SHALL load counter and go to START.
REQ-018 START: after HALF cycles SHALL resample; if 0 go to DATA with bit index 0, if 1 (glitch) return to IDLE with no push and no error.
REQ-019 DATA: SHALL sample every BIT_CNT cycles at bit centre, shift LSB-first into the byte, and go to STOP after the 8th sample.
REQ-020 STOP: after BIT_CNT cycles SHALL sample stop bit: 1 -> push byte; 0 -> discard byte, set frame_err, and go to IDLE only once rx is high (break hold-off).
REQ-021 Push when full SHALL drop the byte, set overrun, and leave FIFO contents unchanged.
REQ-022 rd_en with empty = 0 SHALL update rd_data on the next rising edge and advance the read pointer; rd_en when empty SHALL be ignored, with rd_data held.
REQ-023 Simultaneous push and pop SHALL both take effect; pop when full plus push in the same cycle SHALL NOT set overrun.
REQ-024 Pointers SHALL be SIZE_W+1 bits with wrap bit: empty = pointers equal; full = only MSB differs.
REQ-025 err_clr coincident with a new error event SHALL leave the flag set, giving the event priority.
REQ-026 Back-to-back frames with no idle gap beyond the stop bit SHALL be received without loss.

Reset
REQ-027 Asserting rst SHALL immediately force: FSM IDLE, counters 0, pointers 0, rd_data 0, frame_err 0, overrun 0, synchronizer 1, empty 1, full 0.
REQ-028 Reset mid-frame SHALL abandon the partial byte; after release, a frame SHALL be accepted only from a fresh falling edge.

Structure
REQ-029 A shared package uart_pkg SHALL hold the rx_state_t enum and a function computing BIT_CNT from CLK_FREQ and UART_BAUD.
REQ-030 Storage SHALL be one sub-module, the team FIFO (WIDTH=8, SIZE_W), adapted to active-low reset; FSM and timing stay in uart_rx.

Verification (CLK_FREQ=1_000_000, UART_BAUD=100_000 -> BIT_CNT=10, HALF=5)
REQ-031 Send 0x55 with valid stop -> empty falls; rd_en pulse -> rd_data=0x55 next cycle; empty=1; no error flags.
REQ-032 rx low for 3 cycles then high -> no push, FSM back to IDLE, no flags set.
REQ-033 Send 0xA5 with stop bit 0, then hold rx low for 30 cycles -> frame_err=1, FIFO empty, next valid frame 0x3C is received correctly.
REQ-034 Send 9 frames 0x30..0x38, no reads, SIZE_W=3 -> full=1, overrun=1; 8 pops return 0x30..0x37 in order; err_clr clears overrun.
REQ-035 Assert rst during bit 4 of 0xFF, release, send 0x81 -> exactly one byte, 0x81, is in the FIFO.
REQ-036 Back-to-back 0x00 then 0xFF with pop in the same cycle as the second push while full -> both bytes appear in order, overrun stays 0.
